// File: rtl/cpu_pkg.sv
// Shared CPU phase encoding used by the sequencer,
// register-load logic and memory muxes.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_FETCH   = 2'd1,
    ST_OPERAND = 2'd2,
    ST_EXECUTE = 2'd3
  } phase_t;

  localparam int unsigned PHASES = 3;

  function automatic logic is_active(phase_t s);
    return s != ST_HALTED;
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Memory/debug inputs and phase strobe outputs
// exchanged between the sequencer and the CPU datapath.
interface phase_sequencer_if #(
  parameter int P_CNT_W = 16
);
  import cpu_pkg::*;

  logic               i_MEMREADY;
  logic               i_HALT;
  logic               i_RUN;
  logic               i_STEP;
  logic               o_CYCLEX;
  logic               o_CYCLEY;
  logic               o_CYCLEZ;
  logic [1:0]         o_STATE;
  logic               o_HALTED;
  logic               o_FAULT;
  logic [P_CNT_W-1:0] o_INSTRET;

  modport master (
    output i_MEMREADY, i_HALT, i_RUN, i_STEP,
    input  o_CYCLEX, o_CYCLEY, o_CYCLEZ,
    input  o_STATE, o_HALTED, o_FAULT, o_INSTRET
  );

  modport slave (
    input  i_MEMREADY, i_HALT, i_RUN, i_STEP,
    output o_CYCLEX, o_CYCLEY, o_CYCLEZ,
    output o_STATE, o_HALTED, o_FAULT, o_INSTRET
  );

endinterface

// File: rtl/stall_watchdog.sv
// Saturating count of consecutive stalled cycles;
// flags the edge on which the count reaches the limit.
module stall_watchdog #(
  parameter int P_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam bit EN = P_TIMEOUT > 0;
  localparam int W =
    EN ? $clog2(P_TIMEOUT + 1) : 1;
  localparam int LAST_I =
    EN ? P_TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LIM  = W'(P_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(LAST_I);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != LIM)
      cnt_d = cnt_q + W'(1);
  end

  // Fires on the edge that would bring the count to the limit.
  assign expired_o =
    EN && inc_i && !clr_i && (cnt_q >= LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_sequencer.sv
// Fetch/operand/execute phase FSM with memory stalls,
// halt/run/step debug control and retired counter.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int P_CNT_W        = 16,
  parameter int P_TIMEOUT      = 255,
  parameter bit P_START_HALTED = 1'b0
) (
  input  logic               i_CLOCK,
  input  logic               i_RESET_N,
  phase_sequencer_if.slave   bus
);

  localparam phase_t ST_RST =
    P_START_HALTED ? ST_HALTED : ST_FETCH;

  phase_t             state_q;
  logic               x_q;
  logic               y_q;
  logic               z_q;
  logic               fault_q;
  logic               step_q;
  logic [P_CNT_W-1:0] instret_q;

  logic active;
  logic wd_clr;
  logic wd_inc;
  logic expired;

  assign active = is_active(state_q);
  assign wd_clr = !active || bus.i_MEMREADY;
  assign wd_inc = active && !bus.i_MEMREADY;

  stall_watchdog #(
    .P_TIMEOUT (P_TIMEOUT)
  ) u_wd (
    .clk_i     (i_CLOCK),
    .rst_ni    (i_RESET_N),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .expired_o (expired)
  );

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q   <= ST_RST;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      z_q       <= 1'b0;
      fault_q   <= 1'b0;
      step_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      x_q <= 1'b0;
      y_q <= 1'b0;
      z_q <= 1'b0;
      if (expired) begin
        // Aborted instruction is dropped; RUN restarts at fetch.
        state_q <= ST_HALTED;
        fault_q <= 1'b1;
        step_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_HALTED: begin
            if (bus.i_RUN) begin
              if (!bus.i_HALT) begin
                state_q <= ST_FETCH;
                fault_q <= 1'b0;
                step_q  <= 1'b0;
              end
            end else if (bus.i_STEP) begin
              state_q <= ST_FETCH;
              step_q  <= 1'b1;
            end
          end
          ST_FETCH: begin
            if (bus.i_MEMREADY) begin
              state_q <= ST_OPERAND;
              x_q     <= 1'b1;
            end
          end
          ST_OPERAND: begin
            if (bus.i_MEMREADY) begin
              state_q <= ST_EXECUTE;
              y_q     <= 1'b1;
            end
          end
          ST_EXECUTE: begin
            if (bus.i_MEMREADY) begin
              z_q       <= 1'b1;
              instret_q <= instret_q + P_CNT_W'(1);
              step_q    <= 1'b0;
              state_q   <= (bus.i_HALT || step_q)
                         ? ST_HALTED : ST_FETCH;
            end
          end
          default: state_q <= ST_HALTED;
        endcase
      end
    end
  end

  assign bus.o_CYCLEX  = x_q;
  assign bus.o_CYCLEY  = y_q;
  assign bus.o_CYCLEZ  = z_q;
  assign bus.o_STATE   = state_q;
  assign bus.o_HALTED  = (state_q == ST_HALTED);
  assign bus.o_FAULT   = fault_q;
  assign bus.o_INSTRET = instret_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed checks of phase sequencing, stalls, debug
// control, watchdog fault and asynchronous reset.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy, hlt, run, stp;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.P_CNT_W(16)) bus ();
  phase_sequencer_if #(.P_CNT_W(16)) wbus ();

  assign bus.i_MEMREADY  = rdy;
  assign bus.i_HALT      = hlt;
  assign bus.i_RUN       = run;
  assign bus.i_STEP      = stp;
  assign wbus.i_MEMREADY = rdy;
  assign wbus.i_HALT     = hlt;
  assign wbus.i_RUN      = run;
  assign wbus.i_STEP     = stp;

  phase_sequencer #(
    .P_CNT_W (16), .P_TIMEOUT (255), .P_START_HALTED (1'b0)
  ) dut (
    .i_CLOCK (clk), .i_RESET_N (rst_n), .bus (bus)
  );

  phase_sequencer #(
    .P_CNT_W (16), .P_TIMEOUT (4), .P_START_HALTED (1'b0)
  ) dut_wd (
    .i_CLOCK (clk), .i_RESET_N (rst_n), .bus (wbus)
  );

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int strb();
    return int'({bus.o_CYCLEX, bus.o_CYCLEY, bus.o_CYCLEZ});
  endfunction

  task automatic phase(string tag, int st, int sb);
    tick();
    chk({tag, "_st"}, int'(bus.o_STATE), st);
    chk({tag, "_sb"}, strb(), sb);
  endtask

  initial begin
    rdy = 1'b1; hlt = 1'b0; run = 1'b0; stp = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_st", int'(bus.o_STATE), 1);
    chk("rst_sb", strb(), 0);
    chk("rst_ir", int'(bus.o_INSTRET), 0);
    chk("rst_flt", int'(bus.o_FAULT), 0);
    chk("rst_hlt", int'(bus.o_HALTED), 0);
    #9 rst_n = 1'b1;

    // four back-to-back instructions
    for (int i = 0; i < 4; i++) begin
      phase("run_x", 2, 4);
      phase("run_y", 3, 2);
      phase("run_z", 1, 1);
    end
    chk("run_ir", int'(bus.o_INSTRET), 4);

    // five stalled cycles in operand
    phase("stl_x", 2, 4);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++)
      phase("stl_hold", 2, 0);
    rdy = 1'b1;
    phase("stl_y", 3, 2);
    phase("stl_z", 1, 1);
    chk("stl_ir", int'(bus.o_INSTRET), 5);

    // halt request during fetch finishes the instruction
    hlt = 1'b1;
    phase("hlt_x", 2, 4);
    phase("hlt_y", 3, 2);
    phase("hlt_z", 0, 1);
    chk("hlt_h", int'(bus.o_HALTED), 1);
    chk("hlt_ir", int'(bus.o_INSTRET), 6);
    for (int i = 0; i < 3; i++)
      phase("hlt_idle", 0, 0);
    hlt = 1'b0;
    phase("hlt_idle2", 0, 0);

    // single step
    stp = 1'b1;
    phase("stp_f", 1, 0);
    stp = 1'b0;
    phase("stp_x", 2, 4);
    phase("stp_y", 3, 2);
    phase("stp_z", 0, 1);
    chk("stp_ir", int'(bus.o_INSTRET), 7);
    chk("stp_h", int'(bus.o_HALTED), 1);
    phase("stp_idle", 0, 0);

    // run and step together: continuous run
    run = 1'b1; stp = 1'b1;
    phase("rs_f", 1, 0);
    run = 1'b0; stp = 1'b0;
    phase("rs_x", 2, 4);
    phase("rs_y", 3, 2);
    phase("rs_z", 1, 1);
    chk("rs_ir", int'(bus.o_INSTRET), 8);
    phase("rs_x2", 2, 4);
    phase("rs_y2", 3, 2);

    // async reset mid-execute, no clock edge
    rst_n = 1'b0;
    #2;
    chk("ar_st", int'(bus.o_STATE), 1);
    chk("ar_sb", strb(), 0);
    chk("ar_ir", int'(bus.o_INSTRET), 0);
    rdy = 1'b0;
    rst_n = 1'b1;

    // watchdog with limit 4
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_st", int'(wbus.o_STATE), 1);
      chk("wd_flt0", int'(wbus.o_FAULT), 0);
    end
    tick();
    chk("wd_flt", int'(wbus.o_FAULT), 1);
    chk("wd_h", int'(wbus.o_HALTED), 1);
    chk("wd_st0", int'(wbus.o_STATE), 0);
    chk("wd_ir", int'(wbus.o_INSTRET), 0);
    chk("wd_sb", int'({wbus.o_CYCLEX, wbus.o_CYCLEY,
                       wbus.o_CYCLEZ}), 0);
    chk("main_st", int'(bus.o_STATE), 1);
    chk("main_flt", int'(bus.o_FAULT), 0);
    tick();
    chk("wd_stick", int'(wbus.o_FAULT), 1);
    rdy = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    chk("wd_clr", int'(wbus.o_FAULT), 0);
    chk("wd_rst", int'(wbus.o_STATE), 1);
    tick();
    chk("wd_x", int'(wbus.o_CYCLEX), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Single-clock replacement for the divided-clock scheme. Generates the fetch / operand / execute phase strobes and the 2-bit phase state that the CPU datapath muxes and register loads key on.
- Adds three things the divider lacks: memory wait-state stalls, halt/run/single-step debug control, and a stall watchdog.
- Sits between the top-level clock/reset and the CPU's memory, registers, ALU, operand and instruction registers.
- Also exports a retired-instruction counter.

Parameters:
- P_CNT_W, 16: width of the retired-instruction counter.
- P_TIMEOUT, 255: maximum consecutive stalled cycles in one phase before a fault is raised; 0 disables the watchdog.
- P_START_HALTED, 0: 1 means the sequencer leaves reset in HALTED instead of running.

Ports:
- i_CLOCK  in  1  system clock; all state changes on the rising edge.
- i_RESET_N  in  1  asynchronous, active-low reset.
- i_MEMREADY  in  1  memory has data valid for the current phase; 0 stalls the phase.
- i_HALT  in  1  level request to stop at the next instruction boundary.
- i_RUN  in  1  pulse: resume continuous execution from HALTED; also clears the fault.
- i_STEP  in  1  pulse: execute exactly one instruction from HALTED.
- o_CYCLEX  out  1  one-clock strobe: fetch phase completed (instruction-register load).
- o_CYCLEY  out  1  one-clock strobe: operand phase completed (operand / ALU load).
- o_CYCLEZ  out  1  one-clock strobe: execute phase completed (write-back, PC update).
- o_STATE  out  2  current phase: 0 = halted/reset, 1 = fetch, 2 = operand, 3 = execute.
- o_HALTED  out  1  sequencer is in HALTED.
- o_FAULT  out  1  sticky watchdog fault.
- o_INSTRET  out  P_CNT_W  count of completed execute phases.

Behaviour:
- States, with o_STATE encoding: HALTED = 0, FETCH = 1, OPERAND = 2, EXECUTE = 3.
- Reset (async assert, mid-operation included):
  - All strobes 0, o_INSTRET 0, o_FAULT 0, watchdog 0.
  - State goes to HALTED if P_START_HALTED = 1, else FETCH.
  - o_HALTED follows state; o_STATE reads 0 only in HALTED.
- Phase advance:
  - In FETCH, OPERAND or EXECUTE, a rising edge with i_MEMREADY = 1 completes the phase.
  - On completion: the state moves to the next phase, the corresponding strobe is registered high for exactly one clock, and the watchdog clears.
  - While i_MEMREADY = 0: the state holds, all strobes are 0, and the watchdog increments.
  - Minimum instruction time is 3 clocks; each stalled cycle adds one.
- Strobe timing: o_CYCLEX is high during the first cycle of OPERAND; o_CYCLEY during the first cycle of EXECUTE; o_CYCLEZ during the cycle after EXECUTE completes.
- EXECUTE completion (instruction boundary):
  - o_INSTRET increments by 1, wrapping at 2^P_CNT_W.
  - Next state is HALTED if i_HALT = 1 or a step is in progress; otherwise FETCH.
  - i_HALT is sampled only at this edge, so it never truncates an instruction.
- HALTED:
  - No strobes; i_MEMREADY is ignored; the watchdog holds at 0.
  - i_RUN = 1 with i_HALT = 0: go to FETCH and clear o_FAULT.
  - Else i_STEP = 1: go to FETCH and set the internal step flag; the flag clears at the following EXECUTE completion, which returns to HALTED.
  - i_RUN and i_STEP together: RUN wins.
  - i_HALT = 1 together with i_RUN: stay HALTED.
  - i_STEP while running: ignored.
- Watchdog (P_TIMEOUT > 0):
  - When the stall count reaches P_TIMEOUT, at that edge: o_FAULT is set, the state goes to HALTED, no strobe is issued, and o_INSTRET is unchanged.
  - The aborted instruction is not resumed; RUN restarts at FETCH.
  - The counter is $clog2(P_TIMEOUT+1) bits wide and saturates.
- Strobes are mutually exclusive; at most one is high in any cycle.

Decomposition:
- Shared cpu_pkg holds:
  - State encoding constants: ST_HALTED = 2'd0, ST_FETCH = 2'd1, ST_OPERAND = 2'd2, ST_EXECUTE = 2'd3.
  - The phase-state typedef.
  - These are reused by the registers and memory muxes.
- One natural sub-module, stall_watchdog: counter, saturation, and timeout compare, with clear/increment inputs.
- The FSM, step flag, and retired counter live in phase_sequencer.

Test Plan:
- Reset, P_START_HALTED = 0, i_MEMREADY = 1 constant, 4 instructions:
  - o_STATE sequence is 1,2,3,1,2,3…
  - Strobes are X,Y,Z, each exactly 1 clock.
  - o_INSTRET = 4 after 12 clocks.
- i_MEMREADY low for 5 cycles during OPERAND:
  - o_STATE holds at 2 for 6 cycles and no strobes are issued.
  - o_CYCLEY is high in the first cycle after ready returns.
  - Instruction takes 8 clocks.
- i_HALT raised during FETCH:
  - The current instruction completes with X, Y, Z.
  - o_HALTED = 1, o_STATE = 0, o_INSTRET = 1.
  - No further strobes with i_MEMREADY = 1.
- From HALTED, i_STEP pulse: exactly one X/Y/Z triple, o_INSTRET +1, back to HALTED. i_RUN and i_STEP in the same cycle: continuous run.
- P_TIMEOUT = 4, i_MEMREADY held 0 in FETCH:
  - After 4 stalled cycles, o_FAULT = 1, o_HALTED = 1, o_INSTRET unchanged.
  - i_RUN clears o_FAULT and restarts at FETCH.
- i_RESET_N asserted asynchronously mid-EXECUTE: all outputs clear immediately, with no clock edge; the sequence restarts at FETCH on release.
